// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-return bundle for the CPU and HOST requesters plus the data memory port.
// The slave modport is the arbiter's view; master is the surrounding requesters and memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [LEN_W-1:0]  host_len;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_beat;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_len, host_wdata,
        output host_gnt, host_beat, host_rdata, host_rvalid, host_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_len, host_wdata,
        input  host_gnt, host_beat, host_rdata, host_rvalid, host_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (CPU) and the host burst port.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority in IDLE instead of round-robin.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HBURST = 1'b1} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_HOST = 1'b1} owner_t;

    state_t            state;
    owner_t            last_owner;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  burst_len;
    logic [ADDR_W-1:0] burst_base;
    logic              burst_we;

    logic              mem_en_p0;
    logic              mem_we_p0;
    logic [ADDR_W-1:0] mem_addr_p0;
    logic [DATA_W-1:0] mem_wdata_p0;
    owner_t            acc_owner_p0;

    logic              cpu_rvalid_p1;
    logic              host_rvalid_p1;
    logic              host_done_p1;

    logic              cpu_gnt;
    logic              host_gnt;
    logic              last_beat;

    // Zero-length bursts still move one word; oversize requests are clipped to MAX_BURST.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_W'(1);
        else if (int'(len) > MAX_BURST)
            return LEN_W'(MAX_BURST);
        else
            return len;
    endfunction

    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (state == IDLE) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            cpu_gnt  = bus.cpu_req;
            host_gnt = bus.host_req && !bus.cpu_req;
`else
            cpu_gnt  = bus.cpu_req && (!bus.host_req || last_owner == OWN_HOST);
            host_gnt = bus.host_req && (!bus.cpu_req || last_owner == OWN_CPU);
`endif
        end
    end

    assign last_beat = (beat_cnt == burst_len - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_owner     <= OWN_HOST;
            beat_cnt       <= '0;
            burst_len      <= '0;
            burst_base     <= '0;
            burst_we       <= 1'b0;
            mem_en_p0      <= 1'b0;
            mem_we_p0      <= 1'b0;
            mem_addr_p0    <= '0;
            mem_wdata_p0   <= '0;
            acc_owner_p0   <= OWN_HOST;
            cpu_rvalid_p1  <= 1'b0;
            host_rvalid_p1 <= 1'b0;
            host_done_p1   <= 1'b0;
        end else begin
            // p0: issue the memory access for this cycle's accept or burst beat
            mem_en_p0    <= 1'b0;
            mem_we_p0    <= 1'b0;
            host_done_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_gnt) begin
                        mem_en_p0    <= 1'b1;
                        mem_we_p0    <= bus.cpu_we;
                        mem_addr_p0  <= bus.cpu_addr;
                        mem_wdata_p0 <= bus.cpu_wdata;
                        acc_owner_p0 <= OWN_CPU;
                        last_owner   <= OWN_CPU;
                    end else if (host_gnt) begin
                        burst_base <= bus.host_addr;
                        burst_we   <= bus.host_we;
                        burst_len  <= sat_len(bus.host_len);
                        beat_cnt   <= '0;
                        last_owner <= OWN_HOST;
                        state      <= HBURST;
                    end
                end
                HBURST: begin
                    mem_en_p0    <= 1'b1;
                    mem_we_p0    <= burst_we;
                    mem_addr_p0  <= burst_base + ADDR_W'(beat_cnt);
                    mem_wdata_p0 <= bus.host_wdata;
                    acc_owner_p0 <= OWN_HOST;
                    if (last_beat) begin
                        beat_cnt     <= '0;
                        host_done_p1 <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // p1: read data arrives from memory; flag it for the owner of the access
            cpu_rvalid_p1  <= mem_en_p0 && !mem_we_p0 && (acc_owner_p0 == OWN_CPU);
            host_rvalid_p1 <= mem_en_p0 && !mem_we_p0 && (acc_owner_p0 == OWN_HOST);
        end
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.host_beat   = (state == HBURST);
    assign bus.mem_en      = mem_en_p0;
    assign bus.mem_we      = mem_we_p0;
    assign bus.mem_addr    = mem_addr_p0;
    assign bus.mem_wdata   = mem_wdata_p0;
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.host_rdata  = bus.mem_rdata;
    assign bus.cpu_rvalid  = cpu_rvalid_p1;
    assign bus.host_rvalid = host_rvalid_p1;
    assign bus.host_done   = host_done_p1;
endmodule
